// File: rtl/nv_nvdla_noc_axi_resp_pkg.sv
// Shared constants and FSM state types for the NoC-side AXI memory responder.
package nvdla_noc_axi_pkg;

  localparam int DEF_ID_W   = 8;
  localparam int DEF_DATA_W = 64;
  localparam int LEN_W      = 4;

  typedef enum logic [0:0] {
    R_IDLE  = 1'b0,
    R_BURST = 1'b1
  } r_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

endpackage

// File: rtl/nv_nvdla_noc_axi_resp_mem.sv
// Flop-array backing store: one combinational read port, one byte-masked write port.
module nv_nvdla_noc_axi_resp_mem #(
  parameter int MEM_DEPTH = 256,
  parameter int DATA_W    = 64,
  parameter int AW        = $clog2(MEM_DEPTH)
) (
  input  logic                clk_i,
  input  logic [AW-1:0]       rd_idx_i,
  output logic [DATA_W-1:0]   rd_data_o,
  input  logic                we_i,
  input  logic [AW-1:0]       wr_idx_i,
  input  logic [DATA_W-1:0]   wr_data_i,
  input  logic [DATA_W/8-1:0] wr_be_i
);

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];

  // Read is combinational, so a same-cycle write to the same word is seen only after the edge.
  assign rd_data_o = mem_q[rd_idx_i];

  // NOTE: the array has no reset on purpose; contents survive reset and it maps onto plain flops/RAM.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int k = 0; k < DATA_W/8; k++) begin
        if (wr_be_i[k]) mem_q[wr_idx_i][8*k +: 8] <= wr_data_i[8*k +: 8];
      end
    end
  end

endmodule

// File: rtl/nv_nvdla_noc_axi_resp.sv
// AXI-style memory responder on the NoC side of the MCIF; one read and one write burst in flight.
// Optional NVDLA_NOC_RESP_STALL_EN adds LFSR-driven pseudo-random rvalid/wready stalls.
module nv_nvdla_noc_axi_resp
  import nvdla_noc_axi_pkg::*;
#(
  parameter int          DATA_W    = DEF_DATA_W,
  parameter int          ADDR_W    = 32,
  parameter int          ID_W      = DEF_ID_W,
  parameter int          MEM_DEPTH = 256,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              nvdla_core_clk,
  input  logic              nvdla_core_rst,
  input  logic              mcif2noc_axi_ar_arvalid,
  output logic              mcif2noc_axi_ar_arready,
  input  logic [ID_W-1:0]   mcif2noc_axi_ar_arid,
  input  logic [3:0]        mcif2noc_axi_ar_arlen,
  input  logic [ADDR_W-1:0] mcif2noc_axi_ar_araddr,
  input  logic              mcif2noc_axi_aw_awvalid,
  output logic              mcif2noc_axi_aw_awready,
  input  logic [ID_W-1:0]   mcif2noc_axi_aw_awid,
  input  logic [3:0]        mcif2noc_axi_aw_awlen,
  input  logic [ADDR_W-1:0] mcif2noc_axi_aw_awaddr,
  input  logic              mcif2noc_axi_w_wvalid,
  output logic              mcif2noc_axi_w_wready,
  input  logic [DATA_W-1:0] mcif2noc_axi_w_wdata,
  input  logic [31:0]       mcif2noc_axi_w_wstrb,
  input  logic              mcif2noc_axi_w_wlast,
  output logic              noc2mcif_axi_r_rvalid,
  input  logic              noc2mcif_axi_r_rready,
  output logic [ID_W-1:0]   noc2mcif_axi_r_rid,
  output logic              noc2mcif_axi_r_rlast,
  output logic [DATA_W-1:0] noc2mcif_axi_r_rdata,
  output logic              noc2mcif_axi_b_bvalid,
  input  logic              noc2mcif_axi_b_bready,
  output logic [ID_W-1:0]   noc2mcif_axi_b_bid
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam int NB = DATA_W / 8;

  logic              rst;
  r_state_e          r_state_q, r_state_d;
  logic [AW-1:0]     r_idx_q, r_idx_d;
  logic [LEN_W-1:0]  r_cnt_q, r_cnt_d;
  logic [ID_W-1:0]   rid_q, rid_d;
  w_state_e          w_state_q, w_state_d;
  logic [AW-1:0]     w_idx_q, w_idx_d;
  logic [LEN_W-1:0]  w_cnt_q, w_cnt_d;
  logic [ID_W-1:0]   bid_q, bid_d;
  logic              r_stall, w_stall;
  logic              ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic [DATA_W-1:0] mem_rdata;
  logic              unused_in;

  assign rst = nvdla_core_rst;

  // Handshake outputs are gated by reset so every valid/ready reads 0 while reset is held.
  assign mcif2noc_axi_ar_arready = (r_state_q == R_IDLE) && !rst;
  assign noc2mcif_axi_r_rvalid   = (r_state_q == R_BURST) && !r_stall && !rst;
  assign noc2mcif_axi_r_rlast    = (r_state_q == R_BURST) && (r_cnt_q == '0) && !rst;
  assign noc2mcif_axi_r_rdata    = ((r_state_q == R_BURST) && !rst) ? mem_rdata : '0;
  assign noc2mcif_axi_r_rid      = rid_q;
  assign mcif2noc_axi_aw_awready = (w_state_q == W_IDLE) && !rst;
  assign mcif2noc_axi_w_wready   = (w_state_q == W_DATA) && !w_stall && !rst;
  assign noc2mcif_axi_b_bvalid   = (w_state_q == W_RESP) && !rst;
  assign noc2mcif_axi_b_bid      = bid_q;

  assign ar_hs = mcif2noc_axi_ar_arvalid && mcif2noc_axi_ar_arready;
  assign r_hs  = noc2mcif_axi_r_rvalid && noc2mcif_axi_r_rready;
  assign aw_hs = mcif2noc_axi_aw_awvalid && mcif2noc_axi_aw_awready;
  assign w_hs  = mcif2noc_axi_w_wvalid && mcif2noc_axi_w_wready;
  assign b_hs  = noc2mcif_axi_b_bvalid && noc2mcif_axi_b_bready;

  // Address bits outside the word index and wlast carry no meaning here.
  assign unused_in = ^{mcif2noc_axi_ar_araddr[ADDR_W-1:AW+3], mcif2noc_axi_ar_araddr[2:0],
                       mcif2noc_axi_aw_awaddr[ADDR_W-1:AW+3], mcif2noc_axi_aw_awaddr[2:0],
                       mcif2noc_axi_w_wstrb[31:NB], mcif2noc_axi_w_wlast};

`ifdef NVDLA_NOC_RESP_STALL_EN
  logic [15:0] lfsr_q;
  logic        r_hold_q;

  // Once rvalid has been shown without a handshake it is held, so a stall never retracts it.
  always_ff @(posedge nvdla_core_clk) begin
    if (rst) begin
      lfsr_q   <= LFSR_SEED;
      r_hold_q <= 1'b0;
    end else begin
      lfsr_q   <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      r_hold_q <= noc2mcif_axi_r_rvalid && !noc2mcif_axi_r_rready;
    end
  end

  assign r_stall = lfsr_q[0] && !r_hold_q;
  assign w_stall = lfsr_q[0];
`else
  logic unused_seed;
  assign unused_seed = ^LFSR_SEED;
  assign r_stall     = 1'b0;
  assign w_stall     = 1'b0;
`endif

  // NOTE: every next-state variable gets a default first, so no path through the case infers a latch.
  always_comb begin
    r_state_d = r_state_q;
    r_idx_d   = r_idx_q;
    r_cnt_d   = r_cnt_q;
    rid_d     = rid_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          r_state_d = R_BURST;
          r_idx_d   = mcif2noc_axi_ar_araddr[AW+2:3];
          r_cnt_d   = mcif2noc_axi_ar_arlen;
          rid_d     = mcif2noc_axi_ar_arid;
        end
      end
      R_BURST: begin
        if (r_hs) begin
          r_idx_d = r_idx_q + AW'(1);
          if (r_cnt_q == '0) r_state_d = R_IDLE;
          else               r_cnt_d   = r_cnt_q - LEN_W'(1);
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    w_state_d = w_state_q;
    w_idx_d   = w_idx_q;
    w_cnt_d   = w_cnt_q;
    bid_d     = bid_q;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          w_state_d = W_DATA;
          w_idx_d   = mcif2noc_axi_aw_awaddr[AW+2:3];
          w_cnt_d   = mcif2noc_axi_aw_awlen;
          bid_d     = mcif2noc_axi_aw_awid;
        end
      end
      W_DATA: begin
        if (w_hs) begin
          w_idx_d = w_idx_q + AW'(1);
          if (w_cnt_q == '0) w_state_d = W_RESP;
          else               w_cnt_d   = w_cnt_q - LEN_W'(1);
        end
      end
      W_RESP: begin
        if (b_hs) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      r_idx_q   <= '0;
      r_cnt_q   <= '0;
      rid_q     <= '0;
      w_state_q <= W_IDLE;
      w_idx_q   <= '0;
      w_cnt_q   <= '0;
      bid_q     <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_idx_q   <= r_idx_d;
      r_cnt_q   <= r_cnt_d;
      rid_q     <= rid_d;
      w_state_q <= w_state_d;
      w_idx_q   <= w_idx_d;
      w_cnt_q   <= w_cnt_d;
      bid_q     <= bid_d;
    end
  end

  nv_nvdla_noc_axi_resp_mem #(
    .MEM_DEPTH (MEM_DEPTH),
    .DATA_W    (DATA_W),
    .AW        (AW)
  ) u_mem (
    .clk_i     (nvdla_core_clk),
    .rd_idx_i  (r_idx_q),
    .rd_data_o (mem_rdata),
    .we_i      (w_hs),
    .wr_idx_i  (w_idx_q),
    .wr_data_i (mcif2noc_axi_w_wdata),
    .wr_be_i   (mcif2noc_axi_w_wstrb[NB-1:0])
  );

endmodule

// File: tb/tb_nv_nvdla_noc_axi_resp.sv
// Directed bench for nv_nvdla_noc_axi_resp with a transaction-level memory model checked every cycle.
module tb_nv_nvdla_noc_axi_resp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        arvalid = 1'b0, awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0;
  logic        rready = 1'b0, bready = 1'b0;
  logic [7:0]  arid = '0, awid = '0;
  logic [3:0]  arlen = '0, awlen = '0;
  logic [31:0] araddr = '0, awaddr = '0, wstrb = '0;
  logic [63:0] wdata = '0;
  logic        arready, awready, wready, rvalid, rlast, bvalid;
  logic [7:0]  rid, bid;
  logic [63:0] rdata;

  int vectors = 0;
  int miscompares = 0;

  // Transaction model: byte-tracked memory image plus one read and one write burst.
  logic [63:0] mdl [256];
  bit   [7:0]  mk  [256];
  bit          m_r_act, m_w_data, m_w_resp;
  int          m_r_idx, m_r_rem, m_w_idx, m_w_rem;
  logic [7:0]  m_r_id, m_w_id;

  logic [63:0] rd_buf [16];
  logic [63:0] wr_buf [16];
  int          rd_beats, rd_lat, rlast_cnt, rlast_at;
  logic [7:0]  got_bid;

  always #5 clk = ~clk;

  nv_nvdla_noc_axi_resp dut (
    .nvdla_core_clk          (clk),
    .nvdla_core_rst          (rst),
    .mcif2noc_axi_ar_arvalid (arvalid),
    .mcif2noc_axi_ar_arready (arready),
    .mcif2noc_axi_ar_arid    (arid),
    .mcif2noc_axi_ar_arlen   (arlen),
    .mcif2noc_axi_ar_araddr  (araddr),
    .mcif2noc_axi_aw_awvalid (awvalid),
    .mcif2noc_axi_aw_awready (awready),
    .mcif2noc_axi_aw_awid    (awid),
    .mcif2noc_axi_aw_awlen   (awlen),
    .mcif2noc_axi_aw_awaddr  (awaddr),
    .mcif2noc_axi_w_wvalid   (wvalid),
    .mcif2noc_axi_w_wready   (wready),
    .mcif2noc_axi_w_wdata    (wdata),
    .mcif2noc_axi_w_wstrb    (wstrb),
    .mcif2noc_axi_w_wlast    (wlast),
    .noc2mcif_axi_r_rvalid   (rvalid),
    .noc2mcif_axi_r_rready   (rready),
    .noc2mcif_axi_r_rid      (rid),
    .noc2mcif_axi_r_rlast    (rlast),
    .noc2mcif_axi_r_rdata    (rdata),
    .noc2mcif_axi_b_bvalid   (bvalid),
    .noc2mcif_axi_b_bready   (bready),
    .noc2mcif_axi_b_bid      (bid)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] byte_mask(input bit [7:0] m);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) if (m[k]) r[8*k +: 8] = 8'hFF;
    return r;
  endfunction

  // Compare process: outputs are checked at every falling edge against the model,
  // then the model consumes the handshakes that the rising edge will complete.
  initial begin
    for (int i = 0; i < 256; i++) begin
      mdl[i] = '0;
      mk[i]  = '0;
    end
    forever begin
      @(negedge clk);
      if (rst) begin
        check("rst_arready", arready, 0);
        check("rst_awready", awready, 0);
        check("rst_wready", wready, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_rlast", rlast, 0);
        check("rst_rdata", rdata, 0);
        m_r_act  = 0;
        m_w_data = 0;
        m_w_resp = 0;
      end else begin
        check("arready", arready, !m_r_act);
        check("awready", awready, !(m_w_data || m_w_resp));
        check("wready", wready, m_w_data);
        check("rvalid", rvalid, m_r_act);
        check("bvalid", bvalid, m_w_resp);
        if (m_r_act) begin
          check("rid", rid, m_r_id);
          check("rlast", rlast, m_r_rem == 0);
          check("rdata", rdata & byte_mask(mk[m_r_idx]), mdl[m_r_idx] & byte_mask(mk[m_r_idx]));
        end
        if (m_w_resp) check("bid", bid, m_w_id);
        if (m_r_act) begin
          if (rready) begin
            m_r_idx = (m_r_idx + 1) % 256;
            if (m_r_rem == 0) m_r_act = 0;
            else m_r_rem--;
          end
        end else if (arvalid) begin
          m_r_act = 1;
          m_r_idx = int'(araddr[10:3]);
          m_r_rem = int'(arlen);
          m_r_id  = arid;
        end
        if (m_w_data) begin
          if (wvalid) begin
            for (int k = 0; k < 8; k++) begin
              if (wstrb[k]) begin
                mdl[m_w_idx][8*k +: 8] = wdata[8*k +: 8];
                mk[m_w_idx][k] = 1'b1;
              end
            end
            m_w_idx = (m_w_idx + 1) % 256;
            if (m_w_rem == 0) begin
              m_w_data = 0;
              m_w_resp = 1;
            end else m_w_rem--;
          end
        end else if (m_w_resp) begin
          if (bready) m_w_resp = 0;
        end else if (awvalid) begin
          m_w_data = 1;
          m_w_idx  = int'(awaddr[10:3]);
          m_w_rem  = int'(awlen);
          m_w_id   = awid;
        end
      end
    end
  end

  task automatic ar_send(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len);
    bit got = 0;
    arvalid = 1; arid = id; araddr = addr; arlen = len;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = arready;
      @(posedge clk); #1;
    end
    arvalid = 0;
    check("ar_accept", got, 1);
  endtask

  task automatic aw_send(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len);
    bit got = 0;
    awvalid = 1; awid = id; awaddr = addr; awlen = len;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = awready;
      @(posedge clk); #1;
    end
    awvalid = 0;
    check("aw_accept", got, 1);
  endtask

  task automatic write_burst(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                             input logic [31:0] strb);
    bit got;
    aw_send(id, addr, len);
    for (int b = 0; b <= int'(len); b++) begin
      got = 0;
      wvalid = 1; wdata = wr_buf[b]; wstrb = strb; wlast = (b == int'(len));
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clk);
        got = wready;
        @(posedge clk); #1;
      end
      if (!got) check("w_accept", got, 1);
    end
    wvalid = 0; wlast = 0;
    got = 0;
    bready = 1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bvalid) begin
        got = 1;
        got_bid = bid;
      end
      @(posedge clk); #1;
    end
    bready = 0;
    check("b_seen", got, 1);
  endtask

  task automatic read_burst(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input bit toggle);
    int cyc = 0;
    rd_beats = 0; rd_lat = -1; rlast_cnt = 0; rlast_at = -1;
    ar_send(id, addr, len);
    while (rd_beats <= int'(len) && cyc < 100) begin
      rready = toggle ? (cyc % 2 == 0) : 1'b1;
      @(negedge clk);
      if (rvalid && rd_lat < 0) rd_lat = cyc + 1;
      if (rvalid && rready) begin
        rd_buf[rd_beats] = rdata;
        if (rlast) begin
          rlast_cnt++;
          rlast_at = rd_beats;
        end
        rd_beats++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    rready = 0;
    check("r_beats", rd_beats, int'(len) + 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bit got;
    int beats;

    // Reset: ids cleared, readies low; high on the first cycle after release.
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_rid", rid, 0);
    check("rst_bid", bid, 0);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check("post_rst_ready", {arready, awready}, 2'b11);
    @(posedge clk); #1;

    // Single write then read.
    wr_buf[0] = 64'h1122334455667788;
    write_burst(8'h12, 32'h40, 4'd0, 32'hFF);
    check("t1_bid", got_bid, 8'h12);
    read_burst(8'h34, 32'h40, 4'd0, 0);
    check("t1_rdata", rd_buf[0], 64'h1122334455667788);
    check("t1_latency", rd_lat, 1);
    check("t1_rlast", rlast_at, 0);

    // 16-beat burst, read back with rready toggling.
    for (int i = 0; i < 16; i++) wr_buf[i] = 64'(i);
    write_burst(8'h01, 32'h100, 4'd15, 32'hFF);
    read_burst(8'h02, 32'h100, 4'd15, 1);
    for (int i = 0; i < 16; i++) check("t2_beat", rd_buf[i], 64'(i));
    check("t2_rlast_cnt", rlast_cnt, 1);
    check("t2_rlast_at", rlast_at, 15);

    // Byte strobe: upper strobes off keep the preloaded ones.
    wr_buf[0] = '1;
    write_burst(8'h03, 32'h40, 4'd0, 32'hFF);
    wr_buf[0] = '0;
    write_burst(8'h04, 32'h40, 4'd0, 32'hFFFF_FF0F);
    read_burst(8'h05, 32'h40, 4'd0, 0);
    check("t3_strobe", rd_buf[0], 64'hFFFFFFFF00000000);

    // Wrap from word 254 across the top of memory.
    for (int i = 0; i < 4; i++) wr_buf[i] = 64'hA0 + 64'(i);
    write_burst(8'h06, 32'h7F0, 4'd3, 32'hFF);
    read_burst(8'h07, 32'h0, 4'd0, 0);
    check("t4_word0", rd_buf[0], 64'hA2);
    read_burst(8'h08, 32'h8, 4'd0, 0);
    check("t4_word1", rd_buf[0], 64'hA3);
    read_burst(8'h09, 32'h7F0, 4'd3, 0);
    check("t4_word254", rd_buf[0], 64'hA0);
    check("t4_word255", rd_buf[1], 64'hA1);

    // Reset while beat 3 of an 8-beat read is presented.
    ar_send(8'h55, 32'h300, 4'd7);
    rready = 1;
    beats = 0;
    for (int i = 0; i < 50 && beats < 3; i++) begin
      @(negedge clk);
      if (rvalid && rready) beats++;
      @(posedge clk); #1;
    end
    check("t5_beats_before_rst", beats, 3);
    rst = 1;
    @(negedge clk);
    check("t5_rvalid_in_rst", rvalid, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 0;
    rready = 0;
    @(negedge clk);
    check("t5_arready_after", arready, 1);
    @(posedge clk); #1;
    read_burst(8'h56, 32'h40, 4'd0, 0);
    check("t5_new_read", rd_buf[0], 64'hFFFFFFFF00000000);

    // Concurrent AR/AW to word 0x20; W and R beats hit the word in the same cycle.
    arvalid = 1; arid = 8'h77; araddr = 32'h100; arlen = 4'd0;
    awvalid = 1; awid = 8'h66; awaddr = 32'h100; awlen = 4'd0;
    @(negedge clk);
    check("t6_ar_aw_ready", {arready, awready}, 2'b11);
    @(posedge clk); #1;
    arvalid = 0; awvalid = 0;
    wvalid = 1; wdata = 64'hAA; wstrb = 32'hFF; wlast = 1; rready = 1;
    @(negedge clk);
    check("t6_both_hs", {rvalid, wready}, 2'b11);
    check("t6_old_data", rdata, 64'h0);
    @(posedge clk); #1;
    wvalid = 0; wlast = 0; rready = 0; bready = 1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bvalid) begin
        got = 1;
        got_bid = bid;
      end
      @(posedge clk); #1;
    end
    bready = 0;
    check("t6_bid", got_bid, 8'h66);
    read_burst(8'h78, 32'h100, 4'd0, 0);
    check("t6_new_data", rd_buf[0], 64'hAA);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
